// File: rtl/addr_ns_tr_if.sv
// Operand/result handshake bundle for addr_ns_tr, including the fault-injection hooks.
interface addr_ns_tr_if #(
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH:0]      sum;
  logic                err;
  logic                unc;
  logic [ERRCNT_W-1:0] err_count;
  logic                fi_en;
  logic [2:0]          fi_pass;
  logic [WIDTH:0]      fi_mask;

  modport master (
    output in_valid, a, b, out_ready, fi_en, fi_pass, fi_mask,
    input  in_ready, out_valid, sum, err, unc, err_count
  );

  modport slave (
    input  in_valid, a, b, out_ready, fi_en, fi_pass, fi_mask,
    output in_ready, out_valid, sum, err, unc, err_count
  );
endinterface

// File: rtl/addr_ns_tr.sv
// Time-redundant signed adder: one shared adder reused over MODE+1 passes with
// alternate operand encodings; mismatches are flagged (MODE 1) or voted out (MODE 2).
module addr_ns_tr #(
  parameter int WIDTH    = 8,
  parameter int MODE     = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  addr_ns_tr_if.slave  bus
);
  localparam int W1 = WIDTH + 1;

  typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_t;

  state_t              r_state, w_next;
  logic [WIDTH-1:0]    r_a, r_b;
  logic [W1-1:0]       r_r1, r_r2, r_sum;
  logic                r_err, r_unc;
  logic [ERRCNT_W-1:0] r_errcnt;

  logic [W1-1:0] w_ax, w_bx, w_x, w_y, w_raw, w_r, w_post, w_sel;
  logic          w_cin, w_inj, w_last, w_err, w_unc;
  logic [1:0]    w_pidx;

  assign w_ax = {r_a[WIDTH-1], r_a};
  assign w_bx = {r_b[WIDTH-1], r_b};

  // Operand steering for the shared adder; P2 runs the inverted encoding.
  always_comb begin
    w_x    = w_ax;
    w_y    = w_bx;
    w_cin  = 1'b0;
    w_pidx = 2'd0;
    case (r_state)
      P2: begin
        w_x    = ~w_ax;
        w_y    = ~w_bx;
        w_cin  = 1'b1;
        w_pidx = 2'd1;
      end
      P3: begin
        w_x    = w_bx;
        w_y    = w_ax;
        w_pidx = 2'd2;
      end
      default: ;
    endcase
  end

  assign w_raw  = w_x + w_y + W1'(w_cin);
  assign w_inj  = bus.fi_en & bus.fi_pass[w_pidx];
  assign w_r    = w_raw ^ (w_inj ? bus.fi_mask : '0);
  assign w_post = (r_state == P2) ? ~w_r : w_r;

  assign w_last = ((r_state == P1) && (MODE == 0)) ||
                  ((r_state == P2) && (MODE == 1)) ||
                  (r_state == P3);

  // Final-pass result selection; w_post is the current (last) pass result.
  always_comb begin
    w_sel = w_post;
    w_err = 1'b0;
    w_unc = 1'b0;
    if (MODE == 1) begin
      w_sel = r_r1;
      w_err = (r_r1 != w_post);
    end else if (MODE == 2) begin
      w_err = (r_r1 != r_r2) || (r_r1 != w_post);
      if ((r_r1 == r_r2) || (r_r1 == w_post)) begin
        w_sel = r_r1;
      end else if (r_r2 == w_post) begin
        w_sel = r_r2;
      end else begin
        w_sel = r_r1;
        w_unc = 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = P1;
      P1:      w_next = (MODE == 0) ? DONE : P2;
      P2:      w_next = (MODE == 1) ? DONE : P3;
      P3:      w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_sum    <= '0;
      r_err    <= 1'b0;
      r_unc    <= 1'b0;
      r_errcnt <= '0;
    end else begin
      if (r_state == IDLE && bus.in_valid) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      if (r_state == P1) r_r1 <= w_post;
      if (r_state == P2) r_r2 <= w_post;
      if (w_last) begin
        r_sum <= w_sel;
        r_err <= w_err;
        r_unc <= w_unc;
        if (w_err && (r_errcnt != '1)) r_errcnt <= r_errcnt + ERRCNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = ~rst & (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.err       = r_err;
  assign bus.unc       = r_unc;
  assign bus.err_count = r_errcnt;
endmodule
